// File: rtl/onehot_debounce.sv
// Four-line request debouncer feeding a one-hot to binary encoder with a valid/ready output.
// Each accepted press is presented once; overlapping presses raise multi_err instead.
module onehot_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] onehot,
  output logic [1:0] code,
  output logic       multi_err
);

  localparam logic [15:0] MaxCnt = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] AccCnt = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPresent, StWaitRelease} state_e;

  logic [3:0]  r_sync1, r_sync2, r_cand, r_deb;
  logic [15:0] r_cnt;
  state_e      r_state, w_state_next;
  logic        r_valid, w_valid_next;
  logic [3:0]  r_onehot, w_onehot_next;
  logic [1:0]  r_code, w_code_next;
  logic        r_multi, w_multi_next;
  logic        w_single, w_many;

  // Level is accepted only after the counter has seen DEBOUNCE_CYCLES matching samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else begin
        if (r_cnt == AccCnt) r_deb <= r_cand;
        if (r_cnt != MaxCnt) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign w_single = (r_deb != 4'b0000) && ((r_deb & (r_deb - 4'd1)) == 4'b0000);
  assign w_many   = (r_deb != 4'b0000) && !w_single;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_valid  <= 1'b0;
      r_onehot <= 4'b0000;
      r_code   <= 2'b00;
      r_multi  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_valid  <= w_valid_next;
      r_onehot <= w_onehot_next;
      r_code   <= w_code_next;
      r_multi  <= w_multi_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_valid_next  = r_valid;
    w_onehot_next = r_onehot;
    w_code_next   = r_code;
    w_multi_next  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_single) begin
          w_onehot_next = r_deb;
          w_code_next   = {r_deb[3] | r_deb[2], r_deb[3] | r_deb[1]};
          w_valid_next  = 1'b1;
          w_state_next  = StPresent;
        end else if (w_many) begin
          w_multi_next = 1'b1;
          w_state_next = StWaitRelease;
        end
      end
      StPresent: begin
        if (r_valid && out_ready) begin
          w_valid_next = 1'b0;
          w_state_next = StWaitRelease;
        end
      end
      StWaitRelease: begin
        if (r_deb == 4'b0000) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign out_valid = r_valid;
  assign onehot    = r_onehot;
  assign code      = r_code;
  assign multi_err = r_multi;

endmodule

// File: tb/tb_onehot_debounce.sv
// Directed bench for onehot_debounce with DEBOUNCE_CYCLES=4; expected values are hand-derived.
module tb_onehot_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] onehot;
  logic [1:0] code;
  logic       multi_err;

  int total = 0;
  int bad = 0;

  onehot_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (raw),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .onehot    (onehot),
    .code      (code),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for out_valid; an expired budget shows up as a failed comparison.
  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !out_valid; i++) tick();
    check_eq(tag, {31'd0, out_valid}, 32'd1);
  endtask

  int n_valid;
  int n_multi;
  bit ok;

  initial begin
    rst_n = 1'b0;
    raw = 4'b0000;
    out_ready = 1'b1;
    ticks(3);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_onehot", {28'd0, onehot}, 32'd0);
    check_eq("rst_code", {30'd0, code}, 32'd0);
    check_eq("rst_multi", {31'd0, multi_err}, 32'd0);
    rst_n = 1'b1;
    ticks(10);

    // Latency: raw seen at edge T -> valid only in cycle T+7, lasting one cycle.
    raw = 4'b0100;
    ok = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (out_valid !== (i == 8)) ok = 1'b0;
      if (i == 8) begin
        check_eq("lat_onehot", {28'd0, onehot}, 32'h4);
        check_eq("lat_code", {30'd0, code}, 32'h2);
      end
    end
    check_eq("lat_window", {31'd0, ok}, 32'd1);
    raw = 4'b0000;
    ticks(10);

    // Short glitch must be invisible.
    raw = 4'b0001;
    ticks(3);
    raw = 4'b0000;
    n_valid = 0;
    n_multi = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_valid += int'(out_valid);
      n_multi += int'(multi_err);
    end
    check_eq("glitch_valid", n_valid, 0);
    check_eq("glitch_multi", n_multi, 0);

    // Backpressure holds the word; a different key during PRESENT is ignored.
    out_ready = 1'b0;
    raw = 4'b1000;
    wait_valid("bp_wait", 20);
    raw = 4'b0010;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b1 || onehot !== 4'b1000 || code !== 2'b11) ok = 1'b0;
    end
    check_eq("bp_hold", {31'd0, ok}, 32'd1);
    check_eq("bp_code", {30'd0, code}, 32'h3);
    out_ready = 1'b1;
    tick();
    check_eq("bp_drop", {31'd0, out_valid}, 32'd0);
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_valid += int'(out_valid);
    end
    check_eq("bp_no_second", n_valid, 0);
    check_eq("bp_onehot_keep", {28'd0, onehot}, 32'h8);
    raw = 4'b0000;
    ticks(10);
    raw = 4'b0010;
    wait_valid("repress_wait", 20);
    check_eq("repress_code", {30'd0, code}, 32'h1);
    tick();
    check_eq("repress_one_cycle", {31'd0, out_valid}, 32'd0);
    raw = 4'b0000;
    ticks(10);

    // Two keys together: one multi_err pulse, no word.
    raw = 4'b0011;
    n_valid = 0;
    n_multi = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_valid += int'(out_valid);
      n_multi += int'(multi_err);
    end
    check_eq("multi_pulses", n_multi, 1);
    check_eq("multi_valid", n_valid, 0);
    raw = 4'b0000;
    ticks(10);
    raw = 4'b0010;
    wait_valid("multi_recover", 20);
    check_eq("multi_rec_code", {30'd0, code}, 32'h1);
    check_eq("multi_rec_onehot", {28'd0, onehot}, 32'h2);
    raw = 4'b0000;
    ticks(10);

    // Reset while presenting discards the word.
    out_ready = 1'b0;
    raw = 4'b0100;
    wait_valid("rstp_wait", 20);
    raw = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rstp_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rstp_onehot", {28'd0, onehot}, 32'd0);
    check_eq("rstp_code", {30'd0, code}, 32'd0);
    out_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_valid += int'(out_valid);
    end
    check_eq("rstp_quiet", n_valid, 0);

    // Key held through reset release is reported once, 7 cycles after first edge out of reset.
    raw = 4'b1000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (out_valid !== (i == 8)) ok = 1'b0;
      if (i == 8) check_eq("held_code", {30'd0, code}, 32'h3);
    end
    check_eq("held_window", {31'd0, ok}, 32'd1);
    raw = 4'b0000;
    ticks(10);

    // Bouncing input settles to a single word.
    n_valid = 0;
    for (int i = 0; i < 50; i++) begin
      raw = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      n_valid += int'(out_valid);
    end
    check_eq("bounce_quiet", n_valid, 0);
    raw = 4'b0001;
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_valid += int'(out_valid);
      if (out_valid) check_eq("bounce_code", {30'd0, code}, 32'h0);
    end
    check_eq("bounce_once", n_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_debounce.md
ONEHOT_DEBOUNCE -- requirements
Module: onehot_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive identical synchronized samples needed to accept a new input level (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port raw  input  4  asynchronous request lines; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-005 SHALL have port out_ready  input  1  downstream accepts the presented word when high with out_valid.
REQ-006 SHALL have port out_valid  output  1  onehot/code hold a valid accepted request.
REQ-007 SHALL have port onehot  output  4  registered one-hot request {d,c,b,a}, feeding the 4-to-2 encoder stage.
REQ-008 SHALL have port code  output  2  registered binary code: a=00, b=01, c=10, d=11.
REQ-009 SHALL have port multi_err  output  1  one-cycle pulse when a debounced level has more than one bit set.

Function
REQ-010 SHALL pass raw through a 2-flop synchronizer per bit before any other use.
REQ-011 SHALL hold a candidate register and a 16-bit stability counter; counter resets to 0 whenever synchronized value differs from candidate (candidate loads the new value), else increments, saturating at DEBOUNCE_CYCLES.
REQ-012 SHALL update the debounced level to the candidate on the cycle the counter reaches DEBOUNCE_CYCLES-1 with a matching sample; glitches shorter than DEBOUNCE_CYCLES cycles SHALL never change the debounced level.
REQ-013 SHALL implement FSM states IDLE, PRESENT, WAIT_RELEASE; encoding is implementer's choice.
REQ-014 IDLE: debounced level 0 -> stay; exactly one bit set -> load onehot/code, assert out_valid, go PRESENT; two or more bits set -> pulse multi_err one cycle, outputs unchanged, go WAIT_RELEASE.
REQ-015 PRESENT: out_valid, onehot, code SHALL stay constant until out_valid&&out_ready on a rising edge; then out_valid deasserts next cycle, onehot/code hold last value, go WAIT_RELEASE.
REQ-016 PRESENT: release or change of raw SHALL NOT alter or drop the presented word.
REQ-017 WAIT_RELEASE: go IDLE only when debounced level is 0; any nonzero level, including a different single key, SHALL be ignored.
REQ-018 Latency: raw held constant from a rising edge at cycle T (after a debounced 0 level, FSM in IDLE) -> out_valid high at cycle T+DEBOUNCE_CYCLES+3.
REQ-019 out_ready high while out_valid low SHALL have no effect; out_ready tied high SHALL yield exactly one one-cycle out_valid per press.
REQ-020 multi_err SHALL never assert in the same cycle as out_valid rising.
REQ-021 code SHALL always equal the encoding of onehot whenever out_valid is high.

Reset
REQ-022 On rst_n low at a rising edge, synchronizer, candidate, debounced level, counter SHALL clear to 0; FSM to IDLE; out_valid=0, onehot=4'b0000, code=2'b00, multi_err=0.
REQ-023 Reset asserted mid-operation (any state, including PRESENT with a pending word) SHALL discard the word with no out_valid afterwards until a fresh debounced press.
REQ-024 A key held through reset release SHALL be reported once, DEBOUNCE_CYCLES+3 cycles after the first rising edge with rst_n high.

Verification
REQ-025 DEBOUNCE_CYCLES=4, out_ready=1, raw=4'b0100 held from cycle 10 -> out_valid high for exactly cycle 17, onehot=4'b0100, code=2'b10.
REQ-026 DEBOUNCE_CYCLES=4, raw=4'b0001 pulsed 3 cycles then 0 -> out_valid and multi_err never assert.
REQ-027 out_ready=0, raw=4'b1000 held until out_valid, then raw=4'b0010 -> onehot stays 4'b1000, code 2'b11 until out_ready=1; after handshake no second word until raw returns to 0 and 4'b0010 is re-pressed.
REQ-028 raw=4'b0011 held -> one-cycle multi_err pulse, out_valid stays 0; raw=0 then 4'b0010 -> out_valid with code=2'b01.
REQ-029 rst_n low for one cycle while in PRESENT with out_ready=0 -> next cycle out_valid=0, onehot=4'b0000, code=2'b00, FSM IDLE.
REQ-030 raw toggling every 2 cycles for 50 cycles with DEBOUNCE_CYCLES=4 -> no out_valid; settling at 4'b0001 -> single word with code=2'b00.
